// File: rtl/mont_bus_streamer_pkg.sv
// Shared constants and state encoding for the Montgomery operand bus streamer.
package mont_bus_streamer_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned OP_W   = 2048;
  localparam int unsigned WORDS  = OP_W / WORD_W;
  localparam int unsigned IDX_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SEND,
    ST_WAIT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/mont_word_mux.sv
// Selects one bus word from the latched operand pair: idx MSB picks v over u,
// the remaining index bits pick the word within the operand (LSW first).
module mont_word_mux #(
  parameter int unsigned WORD_W = mont_bus_streamer_pkg::WORD_W,
  parameter int unsigned OP_W   = mont_bus_streamer_pkg::OP_W
) (
  input  logic [OP_W-1:0]                        u,
  input  logic [OP_W-1:0]                        v,
  input  logic [mont_bus_streamer_pkg::IDX_W-1:0] idx,
  output logic [WORD_W-1:0]                      word_c
);
  import mont_bus_streamer_pkg::*;

  localparam int unsigned N_WORDS = OP_W / WORD_W;
  localparam int unsigned SEL_W   = IDX_W - 1;

  logic [WORD_W-1:0] u_w [N_WORDS];
  logic [WORD_W-1:0] v_w [N_WORDS];
  logic [SEL_W-1:0]  sel;

  for (genvar i = 0; i < int'(N_WORDS); i++) begin : g_split
    assign u_w[i] = u[i*WORD_W +: WORD_W];
    assign v_w[i] = v[i*WORD_W +: WORD_W];
  end

  assign sel = idx[SEL_W-1:0];

  // Word select: first half of the index range is u, second half is v.
  always_comb begin
    word_c = idx[IDX_W-1] ? v_w[sel] : u_w[sel];
  end

endmodule

// File: rtl/mont_bus_streamer.sv
// Streams a latched u/v operand pair word by word to a multiplier consumer,
// then waits (bounded by TIMEOUT) for its "verified" flag and reports pass.
// Optional feature macro: STREAM_WEIGHT_EN (word-sum of u on the weight port).
module mont_bus_streamer #(
  parameter int unsigned WORD_W  = mont_bus_streamer_pkg::WORD_W,
  parameter int unsigned OP_W    = mont_bus_streamer_pkg::OP_W,
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op_u,
  input  logic [OP_W-1:0]   op_v,
  output logic              mul_reset,
  output logic [WORD_W-1:0] bus,
  input  logic              mul_flag,
  output logic              done,
  output logic              pass,
  output logic [WORD_W+4:0] weight
);
  import mont_bus_streamer_pkg::*;

  localparam int unsigned      N_WORDS    = OP_W / WORD_W;
  localparam int unsigned      WEIGHT_W   = WORD_W + 5;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(2 * N_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_U_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [31:0]      CNT_LAST   = 32'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [OP_W-1:0]   u_q, u_d;
  logic [OP_W-1:0]   v_q, v_d;

  logic              in_ready_q, in_ready_d;
  logic              mul_reset_q, mul_reset_d;
  logic [WORD_W-1:0] bus_q, bus_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [WORD_W-1:0] word_c;

  // Word for the upcoming bus cycle, indexed by the next word index.
  mont_word_mux #(
    .WORD_W (WORD_W),
    .OP_W   (OP_W)
  ) u_word_mux (
    .u      (u_q),
    .v      (v_q),
    .idx    (idx_d),
    .word_c (word_c)
  );

  // State, word index, wait counter and operand latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      u_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
      v_q     <= v_d;
    end
  end

  // Next-state: accept, one-cycle restart, 2*N_WORDS sends, bounded wait, finish.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    u_d     = u_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          u_d     = op_u;
          v_d     = op_v;
          state_d = ST_RST;
        end
      end
      ST_RST: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_WAIT: begin
        if (mul_flag || (cnt_q == CNT_LAST)) begin
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop aligned with its state.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    mul_reset_d = (state_d == ST_RST);
    done_d      = (state_d == ST_FIN);
    bus_d       = (state_d == ST_SEND) ? word_c : '0;
    pass_d      = pass_q;
    if ((state_q == ST_IDLE) && (state_d == ST_RST)) begin
      pass_d = 1'b0;
    end else if ((state_q == ST_WAIT) && (state_d == ST_FIN)) begin
      pass_d = mul_flag;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      mul_reset_q <= 1'b0;
      bus_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      mul_reset_q <= mul_reset_d;
      bus_q       <= bus_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_reset = mul_reset_q;
  assign bus       = bus_q;
  assign done      = done_q;
  assign pass      = pass_q;

`ifdef STREAM_WEIGHT_EN
  logic [WEIGHT_W-1:0] weight_q, weight_d;

  // Word-sum of u: cleared on accept, accumulates each u word as it goes on the bus.
  always_comb begin
    weight_d = weight_q;
    if ((state_q == ST_IDLE) && (state_d == ST_RST)) begin
      weight_d = '0;
    end else if ((state_d == ST_SEND) && (idx_d <= LAST_U_IDX)) begin
      weight_d = weight_q + WEIGHT_W'(word_c);
    end
  end

  // Weight accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_q <= '0;
    end else begin
      weight_q <= weight_d;
    end
  end

  assign weight = weight_q;
`else
  assign weight = '0;
`endif

endmodule

// File: tb/tb_mont_bus_streamer.sv
// Bench for mont_bus_streamer: table of jobs, scoreboard of expected bus words,
// plus hand-written sequences for held in_valid and mid-job reset.
module tb_mont_bus_streamer;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned OP_W    = 2048;
  localparam int unsigned WORDS   = OP_W / WORD_W;
  localparam int unsigned TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op_u;
  logic [OP_W-1:0]   op_v;
  logic              mul_reset;
  logic [WORD_W-1:0] bus;
  logic              mul_flag;
  logic              done;
  logic              pass;
  logic [WORD_W+4:0] weight;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] sb [$];

  typedef struct {
    logic [OP_W-1:0] u;
    logic [OP_W-1:0] v;
    int              flag_at;      // WAIT cycle at which flag rises, -1 = never
    bit              flag_in_send; // flag also high during RST/SEND
    bit              exp_pass;
    int              exp_cyc;      // cycle holding done, accept cycle = 1
  } vec_t;

  vec_t vecs [5];

  mont_bus_streamer #(
    .WORD_W  (WORD_W),
    .OP_W    (OP_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_u      (op_u),
    .op_v      (op_v),
    .mul_reset (mul_reset),
    .bus       (bus),
    .mul_flag  (mul_flag),
    .done      (done),
    .pass      (pass),
    .weight    (weight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] r;
    for (int i = 0; i < int'(OP_W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [WORD_W+4:0] exp_weight(input logic [OP_W-1:0] u);
    logic [WORD_W+4:0] s;
    s = '0;
`ifdef STREAM_WEIGHT_EN
    for (int k = 0; k < int'(WORDS); k++) s = s + (WORD_W+5)'(u[k*WORD_W +: WORD_W]);
`endif
    return s;
  endfunction

  // Bus monitor: after a mul_reset pulse, pop and compare 2*WORDS consecutive words.
  initial begin : monitor
    bit                capturing;
    int                cap_k;
    logic [WORD_W-1:0] exp;
    capturing = 1'b0;
    cap_k     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        capturing = 1'b0;
      end else if (capturing) begin
        if (cap_k == 0) chk("mul_reset_pulse", mul_reset, 1'b0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_k%0d: got %0h expected nothing queued", cap_k, bus);
        end else begin
          exp = sb.pop_front();
          chk($sformatf("bus_k%0d", cap_k), bus, exp);
        end
        cap_k++;
        if (cap_k == int'(2 * WORDS)) capturing = 1'b0;
      end else begin
        chk("bus_idle", bus, '0);
        if (mul_reset) begin
          capturing = 1'b1;
          cap_k     = 0;
        end
      end
    end
  end

  task automatic push_words(input logic [OP_W-1:0] u, input logic [OP_W-1:0] v);
    for (int k = 0; k < int'(WORDS); k++) sb.push_back(u[k*WORD_W +: WORD_W]);
    for (int k = 0; k < int'(WORDS); k++) sb.push_back(v[k*WORD_W +: WORD_W]);
  endtask

  // Runs one job from IDLE (caller is at posedge+1); optionally keeps in_valid
  // high with a second operand pair that must not be latched until IDLE.
  task automatic do_job(input vec_t t, input bit hold_valid,
                        input logic [OP_W-1:0] u2, input logic [OP_W-1:0] v2);
    int c;
    int done_cyc;
    int busy_ready;
    chk("ready_idle", in_ready, 1'b1);
    push_words(t.u, t.v);
    op_u     = t.u;
    op_v     = t.v;
    in_valid = 1'b1;
    mul_flag = 1'b0;
    @(posedge clk);
    #1;
    if (hold_valid) begin
      op_u = u2;
      op_v = v2;
    end else begin
      in_valid = 1'b0;
      op_u     = ~t.u;
      op_v     = ~t.v;
    end
    chk("pass_clear_on_accept", pass, 1'b0);
    chk("weight_clear_on_accept", weight, '0);
    chk("ready_busy_rst", in_ready, 1'b0);
    c          = 2;
    done_cyc   = 0;
    busy_ready = 0;
    while (c < 400 && done_cyc == 0) begin
      mul_flag = ((t.flag_at >= 0) && (c >= 67 + t.flag_at)) || (t.flag_in_send && (c <= 66));
      @(posedge clk);
      #1;
      c++;
      if (in_ready) busy_ready++;
      if (done) done_cyc = c;
    end
    mul_flag = 1'b0;
    chk("done_cycle", done_cyc, t.exp_cyc);
    chk("ready_low_during_job", busy_ready, 0);
    chk("pass_at_done", pass, t.exp_pass);
    chk("weight_at_done", weight, exp_weight(t.u));
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 1'b0);
    chk("ready_after_job", in_ready, 1'b1);
    chk("pass_held", pass, t.exp_pass);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin : main
    int done_seen;
    reset    = 1'b1;
    in_valid = 1'b0;
    op_u     = '0;
    op_v     = '0;
    mul_flag = 1'b0;

    vecs[0] = '{u: OP_W'(1), v: OP_W'(2), flag_at: 10, flag_in_send: 1'b0, exp_pass: 1'b1, exp_cyc: 78};
    vecs[1] = '{u: '1, v: rand_op(), flag_at: -1, flag_in_send: 1'b0, exp_pass: 1'b0, exp_cyc: 167};
    vecs[2] = '{u: rand_op(), v: rand_op(), flag_at: 0, flag_in_send: 1'b0, exp_pass: 1'b1, exp_cyc: 68};
    vecs[3] = '{u: rand_op(), v: rand_op(), flag_at: -1, flag_in_send: 1'b1, exp_pass: 1'b0, exp_cyc: 167};
    vecs[4] = '{u: rand_op(), v: rand_op(), flag_at: 3, flag_in_send: 1'b1, exp_pass: 1'b1, exp_cyc: 71};

    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mul_reset", mul_reset, 1'b0);
    chk("rst_bus", bus, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_weight", weight, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_job(vecs[0], 1'b0, '0, '0);
    do_job(vecs[1], 1'b0, '0, '0);
    // in_valid held through the job with a different pair, which starts the next job
    do_job(vecs[2], 1'b1, vecs[3].u, vecs[3].v);
    do_job(vecs[3], 1'b0, '0, '0);
    do_job(vecs[4], 1'b0, '0, '0);

    // Reset while word 20 is on the bus: job discarded, no done.
    push_words(vecs[4].u, vecs[4].v);
    op_u     = vecs[4].u;
    op_v     = vecs[4].v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("bus_before_reset_k20", bus, vecs[4].u[20*WORD_W +: WORD_W]);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_bus", bus, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_mul_reset", mul_reset, 1'b0);
    chk("midrst_pass", pass, 1'b0);
    chk("midrst_weight", weight, '0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    done_seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("no_done_after_reset", done_seen, 0);
    chk("ready_after_reset", in_ready, 1'b1);

    do_job(vecs[0], 1'b0, '0, '0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
